alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single `alu` instance in the execute stage among `NUM_REQ` requesters. Each requester presents an `alu_op_t` with a valid/ready handshake; the arbiter grants one at a time in round-robin order, drives the registered operation into the ALU, captures `result`/`zero`, and returns them tagged with the requester index. It owns all sequencing around the ALU, which stays purely combinational.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index. Derived; not overridden.
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_op`  in  NUM_REQ x alu_op_t  per-requester operation (`opcode`, `a`, `b`). Must be held stable while `req_valid` is high and not yet accepted.
- `req_ready`  out  NUM_REQ  one-hot grant/accept; at most one bit high.
- `alu_op`  out  alu_op_t  registered operation driven to the ALU `op` input.
- `alu_result`  in  32  ALU `result`.
- `alu_zero`  in  1  ALU `zero`.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_result`  out  32  captured ALU result.
- `rsp_zero`  out  1  captured ALU zero flag.
- `rsp_ready`  in  1  response consumer ready.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Round-robin search starts at `(last_grant+1) mod NUM_REQ` and wraps.
  - The first requester with `req_valid` gets `req_ready[g]=1` combinationally in the same cycle.
  - On that edge: `alu_op <= req_op[g]`, `rsp_id <= g`, `last_grant <= g`, go to EXEC.
  - No valid requester: `req_ready` is all zeros; stay in IDLE.
- EXEC:
  - `alu_op` is held and the ALU evaluates.
  - On the edge: `rsp_result <= alu_result`, `rsp_zero <= alu_zero`, `rsp_valid <= 1`, go to RESP.
  - `req_ready` is all zeros.
- RESP:
  - `rsp_valid`, `rsp_id`, `rsp_result`, and `rsp_zero` stay stable until `rsp_ready` is sampled high.
  - On handshake: `rsp_valid <= 0`, go to IDLE.
  - `req_ready` is all zeros.
- `alu_op` holds its last value outside EXEC. It changes only on a grant.
- Opcodes outside AND/OR/ADD/SUB pass through untouched. The ALU returns 0 for them, so the response is result 0, zero 1. The arbiter does no opcode checking.
- Arithmetic is done by the ALU: 32-bit, wrap-around, no carry or overflow reported.
- Requesters that deassert `req_valid` before grant are simply skipped; no error.
- `req_ready` is forced to 0 while `rst_n` is low.

## Timing
- Reset values (after any cycle with `rst_n`=0):
  - state IDLE, `busy` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_result` 0, `rsp_zero` 0.
  - `alu_op` all-zero.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
- Reset mid-operation (EXEC or RESP) discards the transaction; no response is issued.
- Latency: request accepted at edge k → `rsp_valid` high after edge k+1 → earliest response handshake at edge k+2 → IDLE after k+2 → next grant at edge k+3.
- Peak throughput is one operation per 3 cycles. `rsp_ready` stalls extend RESP indefinitely.
- `req_ready` depends combinationally on `req_valid` and state only, never on `rsp_ready`.
- Simultaneous requests: exactly one is granted per IDLE cycle. The others stay pending and are served in rotating order. With all NUM_REQ requesters continuously valid, each is served once every `3*NUM_REQ` cycles (no starvation).
- A requester granted at edge k may present a new request immediately. It has lowest priority at the next arbitration.

## Test plan
- Single ADD:
  - Stimulus: after reset, `req_valid[2]=1`, op ADD, a=5, b=7.
  - Required: `req_ready[2]` high in the same cycle; `rsp_valid` two edges later with `rsp_id=2`, `rsp_result=12`, `rsp_zero=0`.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously; requester i issues SUB, a=i, b=i.
  - Required: grant order 0,1,2,3,0; every response has result 0, zero 1; grants are 3 cycles apart.
- Backpressure:
  - Stimulus: OR with a=0xF0, b=0x0F; hold `rsp_ready=0` for 5 cycles.
  - Required: `rsp_valid`, `rsp_result=0xFF`, and `rsp_id` stable for all 5 cycles; no `req_ready` asserted; IDLE one edge after `rsp_ready` rises.
- Wrap-around and width:
  - Stimulus: ADD 0xFFFFFFFF + 1, then SUB 0 - 1, then an undefined opcode.
  - Required: results 0 (zero 1), 0xFFFFFFFF (zero 0), 0 (zero 1).
- Reset mid-operation:
  - Stimulus: assert `rst_n=0` during RESP with `rsp_valid` high.
  - Required: next cycle `rsp_valid=0`, `busy=0`, `rsp_result=0`; requester 0 wins the next simultaneous 0/1 request.
- Withdrawn request:
  - Stimulus: requester 1 valid for one cycle while the arbiter is in EXEC, then drops.
  - Required: requester 1 is never granted; no spurious response.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NUM_REQ requesters.
// A granted operation is registered onto the ALU, the result is captured one cycle
// later, and it is returned tagged with the requester index.

package alu_arbiter_pkg;
  localparam logic [3:0] OpAnd = 4'h0;
  localparam logic [3:0] OpOr  = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;

  // Opcode is a plain vector so undefined codes pass through untouched.
  typedef struct packed {
    logic [3:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
  } alu_op_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic    [NUM_REQ-1:0]   req_valid,
  input  alu_op_t [NUM_REQ-1:0]   req_op,
  output logic    [NUM_REQ-1:0]   req_ready,
  output alu_op_t                 alu_op,
  input  logic    [31:0]          alu_result,
  input  logic                    alu_zero,
  output logic                    rsp_valid,
  output logic    [ID_W-1:0]      rsp_id,
  output logic    [31:0]          rsp_result,
  output logic                    rsp_zero,
  input  logic                    rsp_ready,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q;
  logic [ID_W-1:0] last_grant_q;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand_idx;
  logic            gnt_found;
  int unsigned     cand;

  // Round-robin search: first valid requester after the last grant, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last_grant_q) + i) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // Accept is offered only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign busy = (state_q != StIdle);

  // Sequencing FSM: grant -> execute -> hold response until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      alu_op       <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      // Requester 0 gets first priority after reset.
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_found) begin
            alu_op       <= req_op[gnt_idx];
            rsp_id       <= gnt_idx;
            last_grant_q <= gnt_idx;
            state_q      <= StExec;
          end
        end
        StExec: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed test-plan steps followed by random traffic, all
// checked every cycle against a transaction-level model of the arbiter.

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic    [N-1:0]  req_valid;
  alu_op_t [N-1:0]  req_op;
  logic    [N-1:0]  req_ready;
  alu_op_t          alu_op;
  logic    [31:0]   alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic    [1:0]    rsp_id;
  logic    [31:0]   rsp_result;
  logic             rsp_zero;
  logic             rsp_ready;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  // Behavioural ALU: 32-bit wrap-around, 0 for undefined opcodes.
  function automatic logic [31:0] alu_fn(input alu_op_t op);
    case (op.opcode)
      OpAnd:   return op.a & op.b;
      OpOr:    return op.a | op.b;
      OpAdd:   return op.a + op.b;
      OpSub:   return op.a - op.b;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op);
  assign alu_zero   = (alu_result == 32'h0);

  // Transaction-level model: one transaction in flight, age counts edges since grant.
  bit          m_active;
  int          m_age;
  int          m_last;
  int          m_id;
  int          m_g;
  alu_op_t     m_op;
  logic [31:0] m_res;
  int          cyc_n = 0;
  int          grants[$];
  int          gcyc[$];

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int exp_grant();
    for (int i = 1; i <= N; i++) begin
      if (req_valid[(m_last + i) % N]) return (m_last + i) % N;
    end
    return -1;
  endfunction

  // One clock: compare at negedge, advance the model at posedge, return at posedge+1.
  task automatic cyc();
    logic [N-1:0] exp_rdy;
    bit           exp_rv;
    @(negedge clk);
    m_g     = (!m_active && rst_n) ? exp_grant() : -1;
    exp_rdy = '0;
    if (m_g >= 0) exp_rdy[m_g] = 1'b1;
    exp_rv  = m_active && (m_age >= 1);
    check("req_ready", 68'(req_ready), 68'(exp_rdy));
    check("busy", 68'(busy), 68'(m_active));
    check("rsp_valid", 68'(rsp_valid), 68'(exp_rv));
    check("alu_op", 68'(alu_op), 68'(m_op));
    if (exp_rv) begin
      check("rsp_id", 68'(rsp_id), 68'(m_id));
      check("rsp_result", 68'(rsp_result), 68'(m_res));
      check("rsp_zero", 68'(rsp_zero), 68'(m_res == 32'h0));
    end
    @(posedge clk);
    cyc_n++;
    if (!rst_n) begin
      m_active = 1'b0;
      m_last   = N - 1;
      m_op     = '0;
    end else if (m_g >= 0) begin
      m_active = 1'b1;
      m_age    = 0;
      m_id     = m_g;
      m_last   = m_g;
      m_op     = req_op[m_g];
      m_res    = alu_fn(req_op[m_g]);
      grants.push_back(m_g);
      gcyc.push_back(cyc_n);
    end else if (m_active) begin
      if (m_age >= 1 && rsp_ready) m_active = 1'b0;
      else m_age++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_active = 1'b0;
    m_last   = N - 1;
    m_op     = '0;
    rst_n    = 1'b1;
  endtask

  task automatic do_op(input int idx, input alu_op_t op, input logic [31:0] er,
                       input logic ez, input string tag);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    req_op[idx]    = op;
    rsp_ready      = 1'b1;
    cyc();
    check({tag, "_gnt"}, 68'(grants[grants.size()-1]), 68'(idx));
    req_valid[idx] = 1'b0;
    cyc();
    check({tag, "_rv"}, 68'(rsp_valid), 68'(1));
    check({tag, "_id"}, 68'(rsp_id), 68'(idx));
    check({tag, "_res"}, 68'(rsp_result), 68'(er));
    check({tag, "_zero"}, 68'(rsp_zero), 68'(ez));
    cyc();
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom % 4)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic alu_op_t rand_op();
    alu_op_t op;
    op.opcode = 4'($urandom_range(0, 5));
    op.a      = rand_word();
    op.b      = rand_word();
    return op;
  endfunction

  initial begin
    int gsz;
    req_valid = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    do_reset();
    check("rst_busy", 68'(busy), 68'(0));
    check("rst_rv", 68'(rsp_valid), 68'(0));
    check("rst_id", 68'(rsp_id), 68'(0));
    check("rst_res", 68'(rsp_result), 68'(0));
    check("rst_zero", 68'(rsp_zero), 68'(0));
    check("rst_aluop", 68'(alu_op), 68'(0));

    // Single ADD on requester 2.
    do_op(2, '{opcode: OpAdd, a: 32'd5, b: 32'd7}, 32'd12, 1'b0, "add");

    // Round-robin fairness from a fresh reset.
    do_reset();
    for (int i = 0; i < N; i++) req_op[i] = '{opcode: OpSub, a: 32'(i), b: 32'(i)};
    req_valid = '1;
    rsp_ready = 1'b1;
    grants.delete();
    gcyc.delete();
    repeat (13) cyc();
    req_valid = '0;
    repeat (3) cyc();
    check("rr_count", 68'(grants.size()), 68'(5));
    for (int k = 0; k < 5 && k < grants.size(); k++) begin
      check("rr_order", 68'(grants[k]), 68'(k % N));
      if (k > 0) check("rr_gap", 68'(gcyc[k] - gcyc[k-1]), 68'(3));
    end

    // Backpressure: response held for 5 stalled cycles, other requesters waiting.
    req_valid    = 4'b0001;
    req_op[0]    = '{opcode: OpOr, a: 32'hF0, b: 32'h0F};
    rsp_ready    = 1'b0;
    cyc();
    req_valid    = 4'b0110;
    req_op[1]    = rand_op();
    req_op[2]    = rand_op();
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("bp_rv", 68'(rsp_valid), 68'(1));
      check("bp_res", 68'(rsp_result), 68'(32'hFF));
      check("bp_id", 68'(rsp_id), 68'(0));
    end
    rsp_ready = 1'b1;
    cyc();
    check("bp_idle", 68'(busy), 68'(0));
    req_valid = '0;
    repeat (2) cyc();

    // Wrap-around and undefined opcode.
    do_op(3, '{opcode: OpAdd, a: 32'hFFFF_FFFF, b: 32'd1}, 32'h0, 1'b1, "wrap_add");
    do_op(3, '{opcode: OpSub, a: 32'd0, b: 32'd1}, 32'hFFFF_FFFF, 1'b0, "wrap_sub");
    do_op(3, '{opcode: 4'hA, a: 32'd9, b: 32'd3}, 32'h0, 1'b1, "undef");

    // Reset while a response is pending.
    req_valid = 4'b0100;
    req_op[2] = '{opcode: OpAdd, a: 32'd1, b: 32'd2};
    rsp_ready = 1'b0;
    cyc();
    req_valid = '0;
    cyc();
    rst_n = 1'b0;
    cyc();
    check("mid_rst_rv", 68'(rsp_valid), 68'(0));
    check("mid_rst_busy", 68'(busy), 68'(0));
    check("mid_rst_res", 68'(rsp_result), 68'(0));
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    req_op[0] = rand_op();
    req_op[1] = rand_op();
    cyc();
    check("mid_rst_prio", 68'(grants[grants.size()-1]), 68'(0));
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    repeat (5) cyc();

    // Withdrawn request while busy is never granted.
    gsz       = grants.size();
    req_valid = 4'b0001;
    req_op[0] = rand_op();
    cyc();
    req_valid = 4'b0010;
    req_op[1] = rand_op();
    cyc();
    req_valid = '0;
    repeat (5) cyc();
    check("wd_grants", 68'(grants.size() - gsz), 68'(1));
    check("wd_who", 68'(grants[grants.size()-1]), 68'(0));
    check("wd_rv", 68'(rsp_valid), 68'(0));

    // Random traffic with withdrawals and response stalls.
    for (int t = 0; t < 400; t++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (i == m_g) begin
          req_valid[i] = 1'($urandom % 2);
          req_op[i]    = rand_op();
        end else if (req_valid[i]) begin
          if ($urandom % 8 == 0) req_valid[i] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          req_valid[i] = 1'b1;
          req_op[i]    = rand_op();
        end
      end
      rsp_ready = ($urandom % 4) != 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
